// File: rtl/axi4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi4_pkg : AXI4 burst-type and response encodings shared by the slave.
// Rev 1.0
// ----------------------------------------------------------------------------
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  function automatic logic burst_supported(input logic [1:0] b);
    return (b == FIXED) || (b == INCR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_dma_mem_slave_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_dma_mem_slave_ram : simple dual-port byte-writable RAM, registered read
// port with enable (stall hold) and synchronous clear. Rev 1.0
// ----------------------------------------------------------------------------
module axi_dma_mem_slave_ram #(
  parameter int DATA_WD = 32,
  parameter int DEPTH   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WD-1:0]         wdata_i,
  input  logic [DATA_WD/8-1:0]       wstrb_i,
  input  logic                       re_i,
  input  logic                       clr_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WD-1:0]         rdata_o
);

  localparam int NB = DATA_WD / 8;

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [DATA_WD-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read-first: a same-cycle write to the read word is not visible here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= clr_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_dma_mem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_dma_mem_slave : AXI4 memory slave with independent INCR/FIXED read and
// write engines over an on-chip byte-writable RAM. Rev 1.0
// ----------------------------------------------------------------------------
module axi_dma_mem_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_ARADDR,
  input  logic [7:0]           S_AXI_ARLEN,
  input  logic [2:0]           S_AXI_ARSIZE,
  input  logic [1:0]           S_AXI_ARBURST,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [DATA_WD-1:0]   S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RLAST,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_AWADDR,
  input  logic [7:0]           S_AXI_AWLEN,
  input  logic [2:0]           S_AXI_AWSIZE,
  input  logic [1:0]           S_AXI_AWBURST,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  input  logic [DATA_WD-1:0]   S_AXI_WDATA,
  input  logic [DATA_WD/8-1:0] S_AXI_WSTRB,
  input  logic                 S_AXI_WLAST,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  output logic [1:0]           S_AXI_BRESP
);

  localparam int LGB = $clog2(DATA_WD / 8);
  localparam int MAW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  // FIXED repeats the start address; otherwise align to the beat size and step.
  function automatic logic [ADDR_WD-1:0] next_addr(input logic [ADDR_WD-1:0] a,
                                                   input logic [2:0] sz,
                                                   input logic [1:0] bt);
    logic [ADDR_WD-1:0] step;
    step = ADDR_WD'(1) << sz;
    if (bt == FIXED) return a;
    return (a & ~(step - ADDR_WD'(1))) + step;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WD-1:0] a);
    return |a[ADDR_WD-1:LGB+MAW];
  endfunction

  function automatic logic burst_bad(input logic [1:0] bt, input logic [2:0] sz);
    return !burst_supported(bt) || (int'(sz) > LGB);
  endfunction

  // ---------------------------------------------------------------- read engine
  rstate_e            r_state_q;
  logic [ADDR_WD-1:0] r_addr_q, r_addr_d;
  logic [7:0]         r_len_q, r_cnt_q;
  logic [2:0]         r_size_q;
  logic [1:0]         r_burst_q;
  logic               r_bad_q;
  logic               arready_q, rvalid_q, rlast_q;
  resp_t              rresp_q;
  logic               r_fetch, r_beat_err;

  assign r_addr_d   = next_addr(r_addr_q, r_size_q, r_burst_q);
  assign r_beat_err = r_bad_q | out_of_range(r_addr_q);
  // RAM fetch runs one beat ahead of the beat on the bus.
  assign r_fetch    = (r_state_q == R_FETCH) ||
                      ((r_state_q == R_DATA) && S_AXI_RREADY && !rlast_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_bad_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      if (r_fetch) begin
        r_addr_q <= r_addr_d;
        r_cnt_q  <= r_cnt_q + 8'd1;
        rlast_q  <= (r_cnt_q == r_len_q);
        rresp_q  <= r_beat_err ? SLVERR : OKAY;
        rvalid_q <= 1'b1;
      end
      case (r_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            r_addr_q  <= S_AXI_ARADDR;
            r_len_q   <= S_AXI_ARLEN;
            r_size_q  <= S_AXI_ARSIZE;
            r_burst_q <= S_AXI_ARBURST;
            r_bad_q   <= burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE);
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: r_state_q <= R_DATA;
        R_DATA: begin
          if (S_AXI_RREADY && rlast_q) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write engine
  wstate_e            w_state_q;
  logic [ADDR_WD-1:0] w_addr_q, w_addr_d;
  logic [7:0]         w_len_q, w_cnt_q;
  logic [2:0]         w_size_q;
  logic [1:0]         w_burst_q;
  logic               w_bad_q, w_err_q;
  logic               awready_q, wready_q, bvalid_q;
  resp_t              bresp_q;
  logic               w_hs, w_last, w_beat_err, w_beat_bad;

  assign w_addr_d   = next_addr(w_addr_q, w_size_q, w_burst_q);
  assign w_hs       = (w_state_q == W_DATA) && S_AXI_WVALID;
  assign w_last     = (w_cnt_q == w_len_q);
  assign w_beat_err = w_bad_q | out_of_range(w_addr_q);
  assign w_beat_bad = w_beat_err | (S_AXI_WLAST != w_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (S_AXI_AWVALID) begin
            w_addr_q  <= S_AXI_AWADDR;
            w_len_q   <= S_AXI_AWLEN;
            w_size_q  <= S_AXI_AWSIZE;
            w_burst_q <= S_AXI_AWBURST;
            w_bad_q   <= burst_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr_q <= w_addr_d;
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_err_q | w_beat_bad;
            if (w_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q | w_beat_bad) ? SLVERR : OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------ RAM
  logic [DATA_WD-1:0] ram_rdata;

  axi_dma_mem_slave_ram #(
    .DATA_WD (DATA_WD),
    .DEPTH   (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_hs && !w_beat_err && rst),
    .waddr_i (w_addr_q[LGB +: MAW]),
    .wdata_i (S_AXI_WDATA),
    .wstrb_i (S_AXI_WSTRB),
    .re_i    (r_fetch),
    .clr_i   (r_beat_err),
    .raddr_i (r_addr_q[LGB +: MAW]),
    .rdata_o (ram_rdata)
  );

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = ram_rdata;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_mem_slave.sv
`default_nettype none
// tb_axi_dma_mem_slave : directed self-checking bench for axi_dma_mem_slave.
module tb_axi_dma_mem_slave;

  localparam int ADDR_WD   = 32;
  localparam int DATA_WD   = 32;
  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  axi_dma_mem_slave #(
    .ADDR_WD (ADDR_WD), .DATA_WD (DATA_WD), .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready), .S_AXI_ARADDR (araddr),
    .S_AXI_ARLEN (arlen), .S_AXI_ARSIZE (arsize), .S_AXI_ARBURST (arburst),
    .S_AXI_RVALID (rvalid), .S_AXI_RREADY (rready), .S_AXI_RDATA (rdata),
    .S_AXI_RRESP (rresp), .S_AXI_RLAST (rlast),
    .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready), .S_AXI_AWADDR (awaddr),
    .S_AXI_AWLEN (awlen), .S_AXI_AWSIZE (awsize), .S_AXI_AWBURST (awburst),
    .S_AXI_WVALID (wvalid), .S_AXI_WREADY (wready), .S_AXI_WDATA (wdata),
    .S_AXI_WSTRB (wstrb), .S_AXI_WLAST (wlast),
    .S_AXI_BVALID (bvalid), .S_AXI_BREADY (bready), .S_AXI_BRESP (bresp)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  int          rlat;
  logic [1:0]  bres, bres2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_arready"}, arready, 1);
    check({p, "_awready"}, awready, 1);
    check({p, "_rvalid"},  rvalid, 0);
    check({p, "_wready"},  wready, 0);
    check({p, "_bvalid"},  bvalid, 0);
    check({p, "_rlast"},   rlast, 0);
    check({p, "_rresp"},   rresp, 0);
    check({p, "_bresp"},   bresp, 0);
    check({p, "_rdata"},   rdata, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input bit thr, output logic [1:0] resp);
    int t;
    logic stalled;
    logic [1:0] sb;
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == len); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin step(); t++; end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    forever begin
      bready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && bready) break;
      stalled = bvalid; sb = bresp;
      step(); t++;
      if (stalled) check("b_stall", {bvalid, bresp}, {1'b1, sb});
      if (t > 200) break;
    end
    if (t > 200) check("b_timeout", bvalid, 1);
    resp = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input bit thr);
    int t;
    logic stalled;
    logic [31:0] sd;
    logic [1:0] sr;
    logic sl;
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    step();
    arvalid = 1'b0;
    rlat = 1;
    while (!rvalid && rlat < 20) begin step(); rlat++; end
    for (int i = 0; i <= len; i++) begin
      t = 0;
      forever begin
        rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rvalid && rready) break;
        stalled = rvalid; sd = rdata; sr = rresp; sl = rlast;
        step(); t++;
        if (stalled) check("r_stall", {rvalid, rdata, rresp, rlast}, {1'b1, sd, sr, sl});
        if (t > 200) break;
      end
      if (t > 200) check("r_timeout", rvalid, 1);
      rbuf[i] = rdata; rrsp[i] = rresp; rlst[i] = rlast;
      step();
    end
    rready = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check_reset("rst");
    rst = 1'b1;
    step();

    // INCR write/read of 4 words at 0x100
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h100, 3, 3'd2, 2'd1, 1'b0, bres);
    check("incr_wr_bresp", bres, 0);
    do_read(32'h100, 3, 3'd2, 2'd1, 1'b0);
    check("incr_rd_latency", rlat, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rd_data[%0d]", i), rbuf[i], 32'hA0 + 32'(i));
      check($sformatf("incr_rd_resp[%0d]", i), rrsp[i], 0);
      check($sformatf("incr_rd_last[%0d]", i), rlst[i], (i == 3));
    end

    // byte strobes
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    do_write(32'h40, 0, 3'd2, 2'd1, 1'b0, bres);
    check("strb_wr1_bresp", bres, 0);
    wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
    do_write(32'h40, 0, 3'd2, 2'd1, 1'b0, bres);
    check("strb_wr2_bresp", bres, 0);
    do_read(32'h40, 0, 3'd2, 2'd1, 1'b0);
    check("strb_rd_data", rbuf[0], 32'hDE22BE44);
    check("strb_rd_last", rlst[0], 1);

    // FIXED write: every beat hits 0x80, last one wins
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(32'h80, 3, 3'd2, 2'd0, 1'b0, bres);
    check("fixed_wr_bresp", bres, 0);
    do_read(32'h80, 0, 3'd2, 2'd1, 1'b0);
    check("fixed_rd_data", rbuf[0], 4);

    // unaligned INCR: 0x102, 0x104, 0x108
    do_read(32'h102, 2, 3'd2, 2'd1, 1'b0);
    check("unal_rd_data0", rbuf[0], 32'hA0);
    check("unal_rd_data1", rbuf[1], 32'hA1);
    check("unal_rd_data2", rbuf[2], 32'hA2);
    check("unal_rd_last2", rlst[2], 1);

    // top word in range, next beat out of range
    wdat[0] = 32'h5A5A0FFC; wstb[0] = 4'hF;
    do_write(32'hFFC, 0, 3'd2, 2'd1, 1'b0, bres);
    check("top_wr_bresp", bres, 0);
    do_read(32'hFFC, 1, 3'd2, 2'd1, 1'b0);
    check("oor_rd_data0", rbuf[0], 32'h5A5A0FFC);
    check("oor_rd_resp0", rrsp[0], 0);
    check("oor_rd_data1", rbuf[1], 0);
    check("oor_rd_resp1", rrsp[1], 2);
    check("oor_rd_last1", rlst[1], 1);

    // WRAP write is rejected and leaves memory alone
    wdat[0] = 32'h00000BAD; wstb[0] = 4'hF;
    do_write(32'h100, 0, 3'd2, 2'd2, 1'b0, bres);
    check("wrap_wr_bresp", bres, 2);
    do_read(32'h100, 0, 3'd2, 2'd1, 1'b0);
    check("wrap_mem_kept", rbuf[0], 32'hA0);
    check("wrap_rd_resp", rrsp[0], 0);

    // oversize read
    do_read(32'h100, 0, 3'd3, 2'd1, 1'b0);
    check("size_rd_data", rbuf[0], 0);
    check("size_rd_resp", rrsp[0], 2);

    // concurrent throttled bursts
    for (int i = 0; i < 16; i++) begin wdat[i] = 32'h3000 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h300, 15, 3'd2, 2'd1, 1'b0, bres);
    check("pre_wr_bresp", bres, 0);
    for (int i = 0; i < 16; i++) wdat[i] = 32'h4000 + 32'(i);
    fork
      do_write(32'h400, 15, 3'd2, 2'd1, 1'b1, bres2);
      do_read(32'h300, 15, 3'd2, 2'd1, 1'b1);
    join
    check("conc_wr_bresp", bres2, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("conc_rd_data[%0d]", i), rbuf[i], 32'h3000 + 32'(i));
      check($sformatf("conc_rd_resp[%0d]", i), rrsp[i], 0);
    end
    check("conc_rd_last", rlst[15], 1);
    do_read(32'h400, 15, 3'd2, 2'd1, 1'b1);
    for (int i = 0; i < 16; i++)
      check($sformatf("conc_wb_data[%0d]", i), rbuf[i], 32'h4000 + 32'(i));

    // reset during beat 2 of a write burst
    awaddr = 32'h500; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    for (int t = 0; t < 50 && !awready; t++) step();
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h5000 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      for (int t = 0; t < 50 && !wready; t++) step();
      step();
    end
    wdata = 32'h5002;
    rst = 1'b0;
    step();
    check_reset("midrst");
    rst = 1'b1; wvalid = 1'b0;
    step();
    wdat[0] = 32'h77; wstb[0] = 4'hF;
    do_write(32'h500, 0, 3'd2, 2'd1, 1'b0, bres);
    check("postrst_bresp", bres, 0);
    do_read(32'h500, 0, 3'd2, 2'd1, 1'b0);
    check("postrst_rd_data", rbuf[0], 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
